mpa_limb_sequencer: RTL and testbench

- Multi-precision add/subtract controller that sits directly upstream of the 32-bit ADD_ADCS_SUBS adder and feeds it.
- Accepts two WORDS×32-bit operands and drives the adder one 32-bit limb per cycle, least-significant first. Carry is chained between limbs.
- Collects the adder's s/c_out into a wide result register and produces N/Z/C/V flags.
- Lets the existing combinational adder perform 64/128-bit ADDS/SUBS without widening it.

---
 rtl/mpa_limb_sequencer.sv | 143 ++++++++++++++
 tb/tb_mpa_limb_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpa_limb_sequencer.sv
// Purpose: sequences a WORDS x 32-bit add/subtract through one external 32-bit
//          combinational adder, LS limb first, chaining carry; assembles result + NZCV.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+WORDS;
//          one operation per WORDS+2 cycles.
// Backpressure: none; start is only honoured in IDLE, ignored while busy (no queuing).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, op, op_a, op_b request strobe, 0=add/1=sub, operands (sampled with start)
//   c_in_ext              initial carry, present only with MPA_CARRY_IN_EN defined
//   add_a/add_b/add_cin/add_op  drive to the external adder
//   add_s/add_cout        combinational return from the external adder
//   result, flag_n/z/c/v  assembled result and flags, valid from done to next start
//   busy, done            busy in RUN/DONE; done is a one-cycle pulse
//
// Optional feature macro: MPA_CARRY_IN_EN (adds c_in_ext for ADCS/SBCS chaining).
module mpa_limb_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
`ifdef MPA_CARRY_IN_EN
  input  logic                  c_in_ext,
`endif
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  output logic                  add_op,
  input  logic [31:0]           add_s,
  input  logic                  add_cout,
  output logic [32*WORDS-1:0]   result,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                state;
  logic [IDX_W-1:0]          idx;
  logic                      carry;
  logic                      op_r;
  logic                      z_acc;
  logic [WORDS-1:0][31:0]    a_r;
  logic [WORDS-1:0][31:0]    b_r;
  logic [WORDS-1:0][31:0]    res_r;

  logic carry_init;
  logic s_zero;
  logic b_eff_msb;

  // Plain subtract needs carry=1 (a + ~b + 1); the optional port lets the
  // caller chain a previous carry/borrow instead.
`ifdef MPA_CARRY_IN_EN
  assign carry_init = c_in_ext;
`else
  assign carry_init = op;
`endif

  assign s_zero    = (add_s == 32'd0);
  // Sign of the effective second operand as the adder sees it.
  assign b_eff_msb = op_r ? ~add_b[31] : add_b[31];

  // Adder drive is combinational from state so it drops to 0 the moment
  // reset asserts or the sequence leaves RUN.
  always_comb begin
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b0;
    add_op  = 1'b0;
    if (state == S_RUN) begin
      add_a   = a_r[idx];
      add_b   = b_r[idx];
      add_cin = carry;
      add_op  = op_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      op_r   <= 1'b0;
      z_acc  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      res_r  <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= op_a;
            b_r   <= op_b;
            op_r  <= op;
            idx   <= '0;
            carry <= carry_init;
            z_acc <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          res_r[idx] <= add_s;
          carry      <= add_cout;
          z_acc      <= z_acc & s_zero;
          if (idx == LAST_IDX) begin
            // Top limb: add_a/add_b currently hold A_top/B_top.
            flag_n <= add_s[31];
            flag_z <= z_acc & s_zero;
            flag_c <= add_cout;
            flag_v <= (add_a[31] == b_eff_msb) & (add_s[31] != add_a[31]);
            state  <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign result = res_r;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

endmodule

// File: tb/tb_mpa_limb_sequencer.sv
// Purpose: scoreboard bench for mpa_limb_sequencer at WORDS=4 and WORDS=2,
//          each DUT wired to a behavioural model of the 32-bit adder.
// Latency: expected done cycle is stored with each queued expectation.
// Backpressure: n/a (stimulus only starts an operation when the DUT is idle).
module tb_mpa_limb_sequencer;

  typedef struct packed {
    logic [127:0] res;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
    logic [31:0]  due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  exp_t q4[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT, WORDS=4 ----------------
  logic         start4, op4, cin4;
  logic [127:0] a4, b4, result4;
  logic [31:0]  add_a4, add_b4, add_s4;
  logic         add_cin4, add_op4, add_cout4;
  logic         n4, z4, c4, v4, busy4, done4;

  always_comb begin
    {add_cout4, add_s4} = add_op4 ? ({1'b0, add_a4} + {1'b0, ~add_b4} + {32'd0, add_cin4})
                                  : ({1'b0, add_a4} + {1'b0,  add_b4} + {32'd0, add_cin4});
  end

  mpa_limb_sequencer #(.WORDS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .op_a(a4), .op_b(b4),
`ifdef MPA_CARRY_IN_EN
    .c_in_ext(cin4),
`endif
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4), .add_op(add_op4),
    .add_s(add_s4), .add_cout(add_cout4), .result(result4),
    .flag_n(n4), .flag_z(z4), .flag_c(c4), .flag_v(v4), .busy(busy4), .done(done4)
  );

  // ---------------- DUT, WORDS=2 ----------------
  logic         start2, op2, cin2;
  logic [63:0]  a2, b2, result2;
  logic [31:0]  add_a2, add_b2, add_s2;
  logic         add_cin2, add_op2, add_cout2;
  logic         n2, z2, c2, v2, busy2, done2;

  always_comb begin
    {add_cout2, add_s2} = add_op2 ? ({1'b0, add_a2} + {1'b0, ~add_b2} + {32'd0, add_cin2})
                                  : ({1'b0, add_a2} + {1'b0,  add_b2} + {32'd0, add_cin2});
  end

  mpa_limb_sequencer #(.WORDS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .op_a(a2), .op_b(b2),
`ifdef MPA_CARRY_IN_EN
    .c_in_ext(cin2),
`endif
    .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2), .add_op(add_op2),
    .add_s(add_s2), .add_cout(add_cout2), .result(result2),
    .flag_n(n2), .flag_z(z2), .flag_c(c2), .flag_v(v2), .busy(busy2), .done(done2)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [127:0] r, input logic n, z, c, v);
    exp_t e;
    e.res = r; e.n = n; e.z = z; e.c = c; e.v = v; e.due = 32'd0;
    return e;
  endfunction

  task automatic issue4(input logic o, input logic ci, input logic [127:0] a,
                        input logic [127:0] b, input exp_t e);
    exp_t ee;
    @(negedge clk);
    start4 = 1'b1; op4 = o; cin4 = ci; a4 = a; b4 = b;
    ee = e;
    ee.due = 32'(cyc + 1 + 4);
    q4.push_back(ee);
    @(negedge clk);
    // Operands are free to change once accepted.
    start4 = 1'b0; op4 = ~o; cin4 = ~ci;
    a4 = {$urandom, $urandom, $urandom, $urandom};
    b4 = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic issue2(input logic o, input logic ci, input logic [63:0] a,
                        input logic [63:0] b, input exp_t e);
    exp_t ee;
    @(negedge clk);
    start2 = 1'b1; op2 = o; cin2 = ci; a2 = a; b2 = b;
    ee = e;
    ee.due = 32'(cyc + 1 + 2);
    q2.push_back(ee);
    @(negedge clk);
    start2 = 1'b0; op2 = ~o; cin2 = ~ci;
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        chk("u4_unexpected_done", 128'd1, 128'd0);
      end else begin
        e = q4.pop_front();
        chk("u4_result", result4, e.res);
        chk("u4_nzcv", {124'd0, n4, z4, c4, v4}, {124'd0, e.n, e.z, e.c, e.v});
        chk("u4_done_cycle", 128'(cyc), 128'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        chk("u2_unexpected_done", 128'd1, 128'd0);
      end else begin
        e = q2.pop_front();
        chk("u2_result", {64'd0, result2}, e.res);
        chk("u2_nzcv", {124'd0, n2, z2, c2, v2}, {124'd0, e.n, e.z, e.c, e.v});
        chk("u2_done_cycle", 128'(cyc), 128'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    start4 = 0; op4 = 0; cin4 = 0; a4 = '0; b4 = '0;
    start2 = 0; op2 = 0; cin2 = 0; a2 = '0; b2 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_result", result4, 128'd0);
    chk("reset_flags_busy_done", {122'd0, n4, z4, c4, v4, busy4, done4}, 128'd0);
    chk("reset_adder_drive", {62'd0, add_a4, add_b4, add_cin4, add_op4}, 128'd0);
    rst_n = 1'b1;

    // Basic decimal add.
    issue4(0, 0, 128'd82347156, 128'd9483, mk(128'd82356639, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
    // Carry from limb 0 into limb 1.
    issue4(0, 0, 128'hFFFF_FFFF, 128'd1, mk(128'h1_0000_0000, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
    // Equal operands subtract to zero, no borrow.
    issue4(1, 1, 128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0,
           128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0, mk(128'd0, 0, 1, 1, 0));
    repeat (5) @(negedge clk);
    // 0 - 1 borrows through every limb.
    issue4(1, 1, 128'd0, 128'd1,
           mk(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0));
    repeat (5) @(negedge clk);
    // All-ones + 1 wraps to zero with carry out.
    issue4(0, 0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
           mk(128'd0, 0, 1, 1, 0));
    repeat (5) @(negedge clk);
    // Most-negative - 1 overflows positive.
    issue4(1, 1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1,
           mk(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0, 0, 1, 1));
    repeat (5) @(negedge clk);

    // 64-bit instance: signed overflow, then negative difference.
    issue2(0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, mk(128'h8000_0000_0000_0000, 1, 0, 0, 1));
    repeat (3) @(negedge clk);
    issue2(1, 1, 64'd5, 64'd7, mk(128'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0));
    repeat (3) @(negedge clk);

    // Start while busy and start during DONE are both ignored.
    issue4(0, 0, 128'd1, 128'd2, mk(128'd3, 0, 0, 0, 0));
    @(negedge clk);
    start4 = 1'b1; op4 = 1'b1; cin4 = 1'b1; a4 = 128'd100; b4 = 128'd50;
    @(negedge clk);
    start4 = 1'b0;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    chk("done_within_budget", 128'(seen), 128'd1);
    start4 = 1'b1; op4 = 1'b0; cin4 = 1'b0; a4 = 128'd7; b4 = 128'd9;
    @(negedge clk);
    start4 = 1'b0;
    chk("start_in_done_ignored_busy", 128'(busy4), 128'd0);
    repeat (8) @(negedge clk);

    // Reset in RUN at idx=2 aborts immediately.
    start4 = 1'b1; op4 = 1'b0; cin4 = 1'b0;
    a4 = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    b4 = 128'h0101_0101_0202_0202_0303_0303_0404_0404;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_adder_a_idx2", 128'(add_a4), 128'h2222_2222);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_result", result4, 128'd0);
    chk("midrun_reset_ctrl", {122'd0, n4, z4, c4, v4, busy4, done4}, 128'd0);
    chk("midrun_reset_adder_drive", {62'd0, add_a4, add_b4, add_cin4, add_op4}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue4(0, 0, 128'd10, 128'd20, mk(128'd30, 0, 0, 0, 0));
    repeat (5) @(negedge clk);

`ifdef MPA_CARRY_IN_EN
    // Externally supplied carry-in on an add.
    issue4(0, 1, 128'd0, 128'd0, mk(128'd1, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
`endif

    repeat (10) @(negedge clk);
    chk("u4_pending_expectations", 128'(q4.size()), 128'd0);
    chk("u2_pending_expectations", 128'(q2.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
